// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } kp_state_t;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    // All rows pulled up: no key in the driven column is down.
    localparam logic [KP_ROWS-1:0] KP_ROWS_IDLE = '1;

    // Index of the lowest-numbered row that is pulled low.
    function automatic logic [1:0] kp_lowest_row(input logic [3:0] rows);
        logic [1:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < KP_ROWS; i++) begin
            if (!rows[i] && !found) begin
                idx   = i[1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Active-low one-cold column drive for a column index.
    function automatic logic [KP_COLS-1:0] kp_col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_tick.sv
// Scan-rate divider: a wrapping counter that pulses tick once per SCAN_DIV cycles.
module keypad_tick #(
    parameter int SCAN_DIV = 27000
) (
    input  logic clk,
    input  logic nrst,
    output logic tick
);

    localparam int             CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count;

    // Free-running counter 0..SCAN_DIV-1
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column drive, row synchronizer, press/release
// debounce and a single-cycle key_valid strobe per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 27000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [KP_ROWS-1:0] row_in,
    output logic [KP_COLS-1:0] col_out,
    output logic [3:0]         key_code,
    output logic               key_valid,
    output logic               key_held
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_TICKS);

    logic               tick;
    logic [KP_ROWS-1:0] rows_meta;
    logic [KP_ROWS-1:0] rows_s;
    kp_state_t          state;
    logic [1:0]         col_idx;
    logic [1:0]         col_next;
    logic [1:0]         row_idx;
    logic [KP_ROWS-1:0] pat;
    logic [7:0]         cnt;
    logic [7:0]         cnt_inc;

    keypad_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk (clk),
        .nrst(nrst),
        .tick(tick)
    );

    // Two-flop synchronizer for the asynchronous rows, idle (all high) in reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rows_meta <= '1;
            rows_s    <= '1;
        end else begin
            rows_meta <= row_in;
            rows_s    <= rows_meta;
        end
    end

    assign col_next = col_idx + 2'd1;
    assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // Scan/debounce FSM; all state and outputs advance only on tick
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= SCAN;
            col_idx   <= '0;
            col_out   <= kp_col_drive(2'd0);
            row_idx   <= '0;
            pat       <= '1;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (rows_s == KP_ROWS_IDLE) begin
                            col_idx <= col_next;
                            col_out <= kp_col_drive(col_next);
                        end else begin
                            row_idx <= kp_lowest_row(rows_s);
                            pat     <= rows_s;
                            // A single-sample debounce accepts on the detecting tick
                            if (DB_LAST <= 8'd1) begin
                                key_code  <= {kp_lowest_row(rows_s), col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                                state     <= HELD;
                            end else begin
                                cnt   <= 8'd1;
                                state <= DEBOUNCE;
                            end
                        end
                    end

                    DEBOUNCE: begin
                        if (rows_s == pat) begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= DB_LAST) begin
                                key_code  <= {row_idx, col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                                state     <= HELD;
                            end
                        end else begin
                            // Bounce: drop the candidate and resume scanning
                            col_idx <= col_next;
                            col_out <= kp_col_drive(col_next);
                            cnt     <= '0;
                            state   <= SCAN;
                        end
                    end

                    HELD: begin
                        if (rows_s != KP_ROWS_IDLE) begin
                            cnt <= '0;
                        end else if (DB_LAST <= 8'd1) begin
                            key_held <= 1'b0;
                            col_idx  <= col_next;
                            col_out  <= kp_col_drive(col_next);
                            cnt      <= '0;
                            state    <= SCAN;
                        end else begin
                            cnt   <= 8'd1;
                            state <= RELEASE;
                        end
                    end

                    RELEASE: begin
                        if (rows_s != KP_ROWS_IDLE) begin
                            cnt   <= '0;
                            state <= HELD;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= DB_LAST) begin
                                key_held <= 1'b0;
                                col_idx  <= col_next;
                                col_out  <= kp_col_drive(col_next);
                                cnt      <= '0;
                                state    <= SCAN;
                            end
                        end
                    end

                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a keypad matrix model.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int TK             = SCAN_DIV;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] key_down;

    int checks    = 0;
    int errors    = 0;
    int n_strobes = 0;
    int exp_q[$];

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row to its column when driven low
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_down[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Lowest row among the pressed keys (all in one column) gives the code
    function automatic int expected_code(input logic [15:0] keys);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c]) return r*4 + c;
        return -1;
    endfunction

    task automatic monitor();
        logic prev_valid;
        int   exp;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (nrst === 1'b1 && key_valid === 1'b1) begin
                n_strobes++;
                check("strobe_width_prev_cycle", prev_valid, 0);
                check("held_at_strobe", key_held, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: key_code=%0d, expected no strobe", key_code);
                end else begin
                    exp = exp_q.pop_front();
                    check("strobe_key_code", key_code, exp);
                end
            end
            prev_valid = (nrst === 1'b1) ? key_valid : 1'b0;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_strobes < target && k < budget) begin
            cyc(1);
            k++;
        end
        check(name, n_strobes, target);
    endtask

    task automatic check_release(input string name);
        int n;
        n = 0;
        while (key_held === 1'b1 && n < 40) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n < 11 || n > 14) begin
            errors++;
            $display("FAIL %s: key_held fell after %0d cycles, expected 11..14", name, n);
        end
    endtask

    logic [3:0]  prev_col;
    logic [3:0]  exp_seq [4];
    logic [15:0] keys;
    int          last_t, nchg, k, base, c, r, r2, hold, dropped;

    initial begin
        fork
            monitor();
        join_none

        exp_seq[0] = 4'b1101;
        exp_seq[1] = 4'b1011;
        exp_seq[2] = 4'b0111;
        exp_seq[3] = 4'b1110;

        nrst     = 1'b0;
        key_down = '0;
        cyc(3);
        check("reset_col_out", col_out, 4'b1110);
        check("reset_key_code", key_code, 0);
        check("reset_key_valid", key_valid, 0);
        check("reset_key_held", key_held, 0);
        nrst = 1'b1;

        // Idle scan: one column step every SCAN_DIV cycles
        prev_col = col_out;
        nchg     = 0;
        last_t   = 0;
        for (int t = 1; t <= 40 && nchg < 4; t++) begin
            cyc(1);
            if (col_out !== prev_col) begin
                check("scan_col_sequence", col_out, exp_seq[nchg]);
                if (nchg > 0) check("scan_col_period", t - last_t, SCAN_DIV);
                last_t   = t;
                prev_col = col_out;
                nchg++;
            end
        end
        check("scan_col_steps", nchg, 4);

        // Clean press of row 2 / column 1
        base = n_strobes;
        exp_q.push_back(9);
        key_down[9] = 1'b1;
        wait_strobes(base + 1, 20 * TK, "press9_strobe");
        cyc(35 * TK);
        check("press9_held", key_held, 1);
        check("press9_single_strobe", n_strobes, base + 1);
        key_down[9] = 1'b0;
        check_release("press9_release");
        cyc(8 * TK);

        // Bouncing press on row 0 / column 3
        k = 0;
        while (col_out !== 4'b0111 && k < 40) begin
            cyc(1);
            k++;
        end
        check("wait_col3", col_out, 4'b0111);
        base = n_strobes;
        key_down[3] = 1'b1;
        cyc(TK);
        key_down[3] = 1'b0;
        cyc(TK);
        check("bounce_no_strobe", n_strobes, base);
        exp_q.push_back(3);
        key_down[3] = 1'b1;
        wait_strobes(base + 1, 30 * TK, "bounce3_strobe");
        cyc(5 * TK);
        key_down[3] = 1'b0;
        check_release("bounce3_release");
        cyc(8 * TK);

        // Two keys in column 0: lowest row wins
        base = n_strobes;
        exp_q.push_back(4);
        key_down[4]  = 1'b1;
        key_down[12] = 1'b1;
        wait_strobes(base + 1, 20 * TK, "multi4_strobe");
        cyc(10 * TK);
        check("multi4_single_strobe", n_strobes, base + 1);
        key_down = '0;
        check_release("multi4_release");
        cyc(8 * TK);

        // Reset while row 3 / column 3 is held
        base = n_strobes;
        exp_q.push_back(15);
        key_down[15] = 1'b1;
        wait_strobes(base + 1, 20 * TK, "hold15_strobe");
        cyc(5 * TK);
        check("hold15_held", key_held, 1);
        nrst = 1'b0;
        #1;
        check("midreset_col_out", col_out, 4'b1110);
        check("midreset_key_code", key_code, 0);
        check("midreset_key_valid", key_valid, 0);
        check("midreset_key_held", key_held, 0);
        cyc(2);
        nrst = 1'b1;
        base = n_strobes;
        exp_q.push_back(15);
        wait_strobes(base + 1, 20 * TK, "redetect15_strobe");
        cyc(3 * TK);
        key_down[15] = 1'b0;
        check_release("redetect15_release");
        cyc(8 * TK);

        // Two-tick release glitch on row 1 / column 2 must not end the hold
        base = n_strobes;
        exp_q.push_back(6);
        key_down[6] = 1'b1;
        wait_strobes(base + 1, 20 * TK, "glitch6_strobe");
        cyc(5 * TK);
        dropped = 0;
        key_down[6] = 1'b0;
        for (int i = 0; i < 2 * TK; i++) begin
            cyc(1);
            if (key_held !== 1'b1) dropped = 1;
        end
        key_down[6] = 1'b1;
        for (int i = 0; i < 6 * TK; i++) begin
            cyc(1);
            if (key_held !== 1'b1) dropped = 1;
        end
        check("glitch6_held_kept", dropped, 0);
        check("glitch6_single_strobe", n_strobes, base + 1);
        key_down[6] = 1'b0;
        check_release("glitch6_release");
        cyc(8 * TK);

        // Random presses, sometimes two keys sharing a column
        for (int i = 0; i < 10; i++) begin
            c    = int'($urandom_range(0, 3));
            r    = int'($urandom_range(0, 3));
            keys = '0;
            keys[r*4+c] = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                r2 = int'($urandom_range(0, 3));
                keys[r2*4+c] = 1'b1;
            end
            hold = int'($urandom_range(12, 30));
            base = n_strobes;
            exp_q.push_back(expected_code(keys));
            key_down = keys;
            cyc(hold * TK);
            check("rand_held", key_held, 1);
            check("rand_strobe_count", n_strobes, base + 1);
            key_down = '0;
            cyc(int'($urandom_range(6, 12)) * TK);
            check("rand_released", key_held, 0);
        end

        cyc(5 * TK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
